// File: rtl/ni_tx.sv
// ni_tx: network-interface transmitter feeding one router input port.
//   Splits a host packet request (pkt_*) plus a payload word stream (pl_*)
//   into head/body/tail flits. A free downstream VC is picked once per packet
//   and held until the tail. One packet in flight, at most one flit per cycle.
// Ports:
//   clk, rst_              clock, async active-low reset
//   pkt_valid/pkt_ready    packet request handshake (pkt_dst, pkt_len)
//   pl_data/pl_valid/pl_ready  payload word stream for body flits
//   odata/ovalid/ovch      flit link into the router input controller
//   irdy/ilck/iack         per-VC ready, lock and read strobe from the router
//   busy                   packet in progress
// Option: define NI_TX_RR_EN for round-robin VC choice with a per-VC
//   outstanding-flit check (iack is only consumed in that build).
`ifndef DATAW
`define DATAW 31
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 31
`define TYPE_LSB 30
`endif
`ifndef VCHF_MSB
`define VCHF_MSB 29
`define VCHF_LSB 29
`endif
`ifndef DST_MSB
`define DST_MSB 7
`define DST_LSB 0
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef TYPE_DATA
`define TYPE_DATA     2'b00
`define TYPE_HEAD     2'b01
`define TYPE_TAIL     2'b10
`define TYPE_HEADTAIL 2'b11
`endif

module ni_tx #(
  parameter int MAXLEN = 15,
  parameter int NI_ID  = 0
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         pkt_valid,
  output logic                         pkt_ready,
  input  logic [`DST_MSB-`DST_LSB:0]   pkt_dst,
  input  logic [3:0]                   pkt_len,
  input  logic [`DATAW:0]              pl_data,
  input  logic                         pl_valid,
  output logic                         pl_ready,
  output logic [`DATAW:0]              odata,
  output logic                         ovalid,
  output logic [`VCHW:0]               ovch,
  input  logic [`VCH:0]                irdy,
  input  logic [`VCH:0]                ilck,
  input  logic [`VCH:0]                iack,
  output logic                         busy
);
  localparam int NVC  = `VCH + 1;
  localparam int VW   = `VCHW + 1;
  localparam int DSTW = `DST_MSB - `DST_LSB + 1;
  localparam logic [3:0] MAXLEN_L = 4'(MAXLEN);

  typedef enum logic [1:0] {IDLE, ARB, HEAD, BODY} state_e;

  state_e          state_q;
  logic [VW-1:0]   vc_q;
  logic [3:0]      len_q;
  logic [3:0]      cnt_q;
  logic [DSTW-1:0] dst_q;
  logic            pkt_ready_q;

  logic [NVC-1:0]  cand;
  logic            found;
  logic [VW-1:0]   pick;
  logic            last;   // tail or headtail flit issues this cycle

`ifdef NI_TX_RR_EN
  logic [NVC-1:0][4:0] cred_q;
  logic [VW-1:0]       rr_q;
`endif

  logic unused_ok;
`ifdef NI_TX_RR_EN
  assign unused_ok = ^{32'(NI_ID)};
`else
  assign unused_ok = ^{iack, 32'(NI_ID)};
`endif

  // VC choice. Scanning from the far end means the preferred candidate
  // (lowest index, or nearest the rr pointer) is the last one written.
  always_comb begin
    cand  = irdy & ~ilck;
    found = 1'b0;
    pick  = '0;
`ifdef NI_TX_RR_EN
    for (int v = 0; v < NVC; v++)
      if (cred_q[v] != '0) cand[v] = 1'b0;
    for (int i = NVC - 1; i >= 0; i--)
      if (cand[(int'(rr_q) + i) % NVC]) begin
        found = 1'b1;
        pick  = VW'((int'(rr_q) + i) % NVC);
      end
`else
    for (int i = NVC - 1; i >= 0; i--)
      if (cand[i]) begin
        found = 1'b1;
        pick  = VW'(i);
      end
`endif
  end

  // Flit datapath: zero-latency from registered state plus irdy/pl_valid.
  always_comb begin
    ovalid   = 1'b0;
    pl_ready = 1'b0;
    odata    = '0;
    last     = 1'b0;
    ovch     = (state_q == HEAD || state_q == BODY) ? vc_q : '0;
    case (state_q)
      HEAD: if (irdy[vc_q]) begin
        ovalid = 1'b1;
        odata[`TYPE_MSB:`TYPE_LSB] = (len_q == 4'd0) ? `TYPE_HEADTAIL : `TYPE_HEAD;
        odata[`DST_MSB:`DST_LSB]   = dst_q;
        odata[`VCHF_MSB:`VCHF_LSB] = vc_q;
        last   = (len_q == 4'd0);
      end
      BODY: if (irdy[vc_q] && pl_valid) begin
        ovalid   = 1'b1;
        pl_ready = 1'b1;
        odata    = pl_data;
        odata[`TYPE_MSB:`TYPE_LSB] = (cnt_q == 4'd1) ? `TYPE_TAIL : `TYPE_DATA;
        odata[`VCHF_MSB:`VCHF_LSB] = vc_q;
        last     = (cnt_q == 4'd1);
      end
      default: ;
    endcase
  end

  assign pkt_ready = pkt_ready_q;
  assign busy      = (state_q != IDLE);

  // pkt_ready is registered so it reads 0 while reset is asserted; it rises
  // on the first clock in IDLE.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      vc_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      dst_q       <= '0;
      pkt_ready_q <= 1'b0;
`ifdef NI_TX_RR_EN
      rr_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (pkt_valid && pkt_ready_q) begin
          dst_q       <= pkt_dst;
          len_q       <= (pkt_len > MAXLEN_L) ? MAXLEN_L : pkt_len;
          pkt_ready_q <= 1'b0;
          state_q     <= ARB;
        end else begin
          pkt_ready_q <= 1'b1;
        end
        ARB: if (found) begin
          vc_q    <= pick;
          state_q <= HEAD;
        end
        HEAD: if (ovalid) begin
          if (last) begin
            state_q     <= IDLE;
            pkt_ready_q <= 1'b1;
          end else begin
            cnt_q   <= len_q;
            state_q <= BODY;
          end
        end
        BODY: if (ovalid) begin
          cnt_q <= cnt_q - 4'd1;
          if (last) begin
            state_q     <= IDLE;
            pkt_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef NI_TX_RR_EN
      if (last) rr_q <= (int'(vc_q) == NVC - 1) ? '0 : vc_q + 1'b1;
`endif
    end
  end

`ifdef NI_TX_RR_EN
  // Outstanding flits per VC: +1 per issued flit, -1 per iack read strobe.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cred_q <= '0;
    end else begin
      for (int v = 0; v < NVC; v++)
        cred_q[v] <= cred_q[v] + {4'b0, (ovalid && ovch == VW'(v))} - {4'b0, iack[v]};
    end
  end
`endif

endmodule

// File: tb/tb_ni_tx.sv
`ifndef DATAW
`define DATAW 31
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 31
`define TYPE_LSB 30
`endif
`ifndef VCHF_MSB
`define VCHF_MSB 29
`define VCHF_LSB 29
`endif
`ifndef DST_MSB
`define DST_MSB 7
`define DST_LSB 0
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef TYPE_DATA
`define TYPE_DATA     2'b00
`define TYPE_HEAD     2'b01
`define TYPE_TAIL     2'b10
`define TYPE_HEADTAIL 2'b11
`endif

module tb_ni_tx;
  localparam int MAXLEN = 6;
  localparam int DW     = `DATAW + 1;
  localparam int DSTW   = `DST_MSB - `DST_LSB + 1;
  localparam int VW     = `VCHW + 1;
  localparam int NVC    = `VCH + 1;

  logic            clk = 1'b0;
  logic            rst_ = 1'b0;
  logic            pkt_valid = 1'b0;
  logic            pkt_ready;
  logic [DSTW-1:0] pkt_dst = '0;
  logic [3:0]      pkt_len = '0;
  logic [DW-1:0]   pl_data = '0;
  logic            pl_valid = 1'b0;
  logic            pl_ready;
  logic [DW-1:0]   odata;
  logic            ovalid;
  logic [VW-1:0]   ovch;
  logic [NVC-1:0]  irdy = '1;
  logic [NVC-1:0]  ilck = '0;
  logic [NVC-1:0]  iack = '0;
  logic            busy;

  always #5 clk = ~clk;

  ni_tx #(.MAXLEN(MAXLEN), .NI_ID(3)) dut (
    .clk(clk), .rst_(rst_),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dst(pkt_dst), .pkt_len(pkt_len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .irdy(irdy), .ilck(ilck), .iack(iack), .busy(busy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [VW-1:0] v;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] pl_q[$];
  logic          pl_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] f_head(input logic [DSTW-1:0] d, input logic ht,
                                           input logic [VW-1:0] v);
    logic [DW-1:0] f;
    f = '0;
    f[`TYPE_MSB:`TYPE_LSB] = ht ? `TYPE_HEADTAIL : `TYPE_HEAD;
    f[`DST_MSB:`DST_LSB]   = d;
    f[`VCHF_MSB:`VCHF_LSB] = v;
    return f;
  endfunction

  function automatic logic [DW-1:0] f_body(input logic [DW-1:0] w, input logic tail,
                                           input logic [VW-1:0] v);
    logic [DW-1:0] f;
    f = w;
    f[`TYPE_MSB:`TYPE_LSB] = tail ? `TYPE_TAIL : `TYPE_DATA;
    f[`VCHF_MSB:`VCHF_LSB] = v;
    return f;
  endfunction

  // Payload source: words are consumed on pl_valid && pl_ready.
  initial begin
    logic fire;
    forever begin
      @(negedge clk);
      fire = pl_valid && pl_ready;
      @(posedge clk);
      #2;
      if (fire && pl_q.size() > 0) void'(pl_q.pop_front());
      pl_valid = pl_en && (pl_q.size() > 0);
      pl_data  = pl_valid ? pl_q[0] : '0;
    end
  end

  // Monitor: every flit on the link is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ && ovalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_flit", {1'b1, odata}, 0);
        end else begin
          e = sb.pop_front();
          chk("flit_data", odata, e.d);
          chk("flit_vch", ovch, e.v);
        end
      end else begin
        chk("odata_idle", odata, 0);
        chk("plr_idle", pl_ready, 0);
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Queue expectations and payload, then pulse the request (IDLE assumed).
  task automatic send(input logic [DSTW-1:0] d, input logic [3:0] len,
                      input logic [VW-1:0] v, input logic [DW-1:0] base);
    int n;
    exp_t e;
    logic [DW-1:0] w;
    n = (len > MAXLEN) ? MAXLEN : int'(len);
    e.d = f_head(d, n == 0, v);
    e.v = v;
    sb.push_back(e);
    for (int i = 0; i < n; i++) begin
      w = base + DW'(i);
      pl_q.push_back(w);
      e.d = f_body(w, i == n - 1, v);
      sb.push_back(e);
    end
    pkt_valid = 1'b1;
    pkt_dst   = d;
    pkt_len   = len;
    cyc();
    pkt_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, busy, 0);
    cyc();
    chk({nm, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int prc;
    logic [5:0] pat;
    exp_t e;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_ready", pkt_ready, 0);
    chk("rst_ovch", ovch, 0);
    @(posedge clk); #1 rst_ = 1'b1;
    cyc();
    @(negedge clk);
    chk("post_rst_pkt_ready", pkt_ready, 1);
    cyc();

`ifndef NI_TX_RR_EN
    // single-flit packet, latency 2 cycles
    e.d = f_head(8'd5, 1'b1, 1'b0); e.v = '0;
    sb.push_back(e);
    pkt_valid = 1'b1; pkt_dst = 8'd5; pkt_len = 4'd0;
    @(negedge clk); chk("t1_idle_busy", busy, 0);
    cyc(); pkt_valid = 1'b0;
    @(negedge clk);
    chk("t1_arb_ovalid", ovalid, 0);
    chk("t1_arb_busy", busy, 1);
    chk("t1_arb_pkt_ready", pkt_ready, 0);
    cyc();
    @(negedge clk);
    chk("t1_head_ovalid", ovalid, 1);
    chk("t1_head_ovch", ovch, 0);
    cyc();
    @(negedge clk);
    chk("t1_done_busy", busy, 0);
    chk("t1_done_pkt_ready", pkt_ready, 1);
    cyc();

    // three-body packet on consecutive cycles
    pl_en = 1'b1;
    send(8'd9, 4'd3, 1'b0, 32'hF0F0_0100);
    @(negedge clk); chk("t2_arb_ovalid", ovalid, 0);
    cyc();
    prc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_stream_ovalid", ovalid, 1);
      chk("t2_stream_ovch", ovch, 0);
      prc += int'(pl_ready);
      cyc();
    end
    @(negedge clk);
    chk("t2_end_ovalid", ovalid, 0);
    chk("t2_end_busy", busy, 0);
    chk("t2_pl_ready_cycles", prc, 3);
    cyc();

    // VC selection: VC0 locked -> VC1; both locked -> hold in ARB
    ilck = 2'b01;
    send(8'd3, 4'd1, 1'b1, 32'hA5A5_0200);
    wait_idle("t3a_idle");
    ilck = 2'b11;
    send(8'd4, 4'd0, 1'b1, '0);
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_ovalid", ovalid, 0);
      chk("t3_hold_busy", busy, 1);
      cyc();
    end
    ilck = 2'b01;
    wait_idle("t3b_idle");

    // stall on irdy[vc] then on pl_valid, on VC1
    send(8'd6, 4'd3, 1'b1, 32'hFFFF_0300);
    cyc();   // HEAD
    cyc();   // first body flit
    irdy = 2'b01;
    repeat (4) begin
      @(negedge clk);
      chk("t4_irdy_stall_ovalid", ovalid, 0);
      chk("t4_irdy_stall_ovch", ovch, 1);
      cyc();
    end
    irdy = 2'b11; pl_en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t4_pl_stall_ovalid", ovalid, 0);
      cyc();
    end
    pl_en = 1'b1;
    wait_idle("t4_idle");
    ilck = 2'b00;

    // back-to-back with pkt_valid held through the first packet
    e.d = f_head(8'h11, 1'b1, 1'b0); e.v = '0;
    sb.push_back(e); sb.push_back(e);
    pkt_valid = 1'b1; pkt_dst = 8'h11; pkt_len = 4'd0;
    pat = 6'b100100;   // bit i = ovalid expected in cycle i
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_b2b_ovalid", ovalid, pat[i]);
      cyc();
      if (i == 3) pkt_valid = 1'b0;
    end
    wait_idle("t5_idle");

    // length clamp: 9 requested, MAXLEN body flits sent
    send(8'd2, 4'd9, 1'b0, 32'h1234_0400);
    wait_idle("t6_clamp_idle");

    // reset mid-BODY (payload runs dry after two words)
    e.d = f_head(8'd7, 1'b0, 1'b0); e.v = '0;
    sb.push_back(e);
    for (int i = 0; i < 2; i++) begin
      pl_q.push_back(32'h0BAD_0500 + i);
      e.d = f_body(32'h0BAD_0500 + i, 1'b0, 1'b0);
      sb.push_back(e);
    end
    pkt_valid = 1'b1; pkt_dst = 8'd7; pkt_len = 4'd5;
    cyc(); pkt_valid = 1'b0;
    repeat (6) cyc();
    chk("t7_stalled_busy", busy, 1);
    rst_ = 1'b0;
    #1;
    chk("t7_rst_ovalid", ovalid, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_pkt_ready", pkt_ready, 0);
    chk("t7_sent_before_rst", sb.size(), 0);
    cyc(); rst_ = 1'b1;
    cyc();
    @(negedge clk);
    chk("t7_release_pkt_ready", pkt_ready, 1);
    chk("t7_release_busy", busy, 0);
    cyc();
`else
    // round-robin with outstanding-flit check
    send(8'd1, 4'd0, 1'b0, '0);
    wait_idle("rr_a_idle");
    send(8'd2, 4'd0, 1'b1, '0);
    wait_idle("rr_b_idle");
    send(8'd3, 4'd0, 1'b0, '0);
    repeat (5) begin
      @(negedge clk);
      chk("rr_hold_ovalid", ovalid, 0);
      chk("rr_hold_busy", busy, 1);
      cyc();
    end
    iack = 2'b01;
    cyc();
    iack = 2'b00;
    wait_idle("rr_c_idle");
`endif

    repeat (3) cyc();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
